// File: rtl/ias_dp_ctrl.sv
// ias_dp_ctrl: command sequencer for the IAS increment/accumulate datapath and its scan register; define IAS_CTRL_ABORT_EN to add a RUN abort input
module ias_dp_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic [WIDTH-1:0] dp_data_in,
  output logic             dp_reg_en,
  output logic             dp_reg_sel,
  output logic             dp_sen,
  output logic             dp_scan_ce,
  output logic             dp_sin,
  input  logic             dp_sout
`ifdef IAS_CTRL_ABORT_EN
  ,
  input  logic             abort
`endif
);
  localparam int SW = $clog2(WIDTH + 1);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, SHIFT, RESP} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] rcnt;
  logic [SW-1:0] scnt;
  logic [WIDTH-1:0] wbuf, cap;
  logic swap, acc, run_stop;
  assign acc = cmd_valid & cmd_ready;
`ifdef IAS_CTRL_ABORT_EN
  assign run_stop = abort;
`else
  assign run_stop = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (acc) state_nx = cmd_op == 2'd0 ? LOAD :
                                cmd_op == 2'd1 ? (cmd_data[CNT_W-1:0] == '0 ? IDLE : RUN) : SHIFT;
      LOAD: state_nx = IDLE;
      RUN: if (run_stop || rcnt == CNT_W'(1)) state_nx = IDLE;
      SHIFT: if (scnt == SW'(1)) state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rcnt <= '0;
      scnt <= '0;
      swap <= 1'b0;
      wbuf <= '0;
      cap <= '0;
      dp_data_in <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        rcnt <= cmd_data[CNT_W-1:0];
        scnt <= SW'(WIDTH);
        swap <= cmd_op == 2'd3;
        wbuf <= cmd_data;
        if (cmd_op == 2'd0) dp_data_in <= cmd_data;
      end else if (state == RUN) begin
        rcnt <= rcnt - 1'b1;
      end else if (state == SHIFT) begin
        scnt <= scnt - 1'b1;
        cap <= {cap[WIDTH-2:0], dp_sout};
        wbuf <= {wbuf[WIDTH-2:0], 1'b0};
      end
    end
  end
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign dp_reg_en = state == LOAD || state == RUN;
  assign dp_reg_sel = state == LOAD;
  assign dp_sen = state == SHIFT;
  assign dp_scan_ce = state == SHIFT;
  assign dp_sin = dp_sen & (swap ? wbuf[WIDTH-1] : dp_sout);
  assign rsp_valid = state == RESP;
  assign rsp_data = cap;
endmodule
